// File: rtl/weight_fetch_sequencer_pkg.sv
// Weight fetch sequencer shared types.
// FSM encoding and a width helper.
package weight_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } wfs_state_e;

  function automatic int wfs_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_fetch_sequencer_skid.sv
// Two-entry FIFO absorbing the memory read latency.
// Head is forced to zero while empty.
module weight_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);
  assign count   = cnt_q;
  assign dout    = (cnt_q != 2'd0) ? mem_q[rd_q] : '0;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Walks a row-major weight matrix in bursts and
// streams it to the MAC array with row/last tags.
module weight_fetch_sequencer
  import weight_fetch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int READ_BURST = 1,
  parameter int ROWS       = 20,
  parameter int COLS       = 30
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         mem_read_enable,
  output logic [ADDR_WIDTH-1:0]        mem_pointer,
  input  logic [DATA_WIDTH*READ_BURST-1:0] mem_data,
  output logic [DATA_WIDTH*READ_BURST-1:0] w_data,
  output logic                         w_valid,
  input  logic                         w_ready,
  output logic [wfs_w(ROWS)-1:0]       w_row,
  output logic                         w_row_last,
  output logic                         w_last,
  output logic                         busy,
  output logic                         done
);

  localparam int BPR   = COLS / READ_BURST;
  localparam int TOTAL = ROWS * BPR;
  localparam int RW    = wfs_w(ROWS);
  localparam int CW    = wfs_w(BPR);
  localparam int IW    = wfs_w(TOTAL + 1);
  localparam int DW    = DATA_WIDTH * READ_BURST;
  localparam int EW    = DW + RW + 2;

  wfs_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         bcol_q, bcol_d;
  logic [IW-1:0]         issued_q, issued_d;
  logic                  done_q, done_d;
  logic                  inflight_q;
  logic [RW+1:0]         tag_q;

  logic                  issue;
  logic                  pop;
  logic                  accept;
  logic                  row_end;
  logic                  mat_end;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] off;
  logic [EW-1:0]         head;

  assign pop     = w_valid && w_ready;
  assign occ     = {1'b0, count} + {2'b0, inflight_q};
  assign issue   = (state_q == S_FETCH)
                && (occ < (3'd2 + {2'b0, pop}));
  assign accept  = (state_q == S_IDLE) && start && !done_q;
  assign row_end = (bcol_q == CW'(BPR - 1));
  assign mat_end = (issued_q == IW'(TOTAL - 1));

  assign off = ADDR_WIDTH'(int'(row_q) * COLS
                         + int'(bcol_q) * READ_BURST);

  assign mem_read_enable = issue;
  assign mem_pointer     = issue ? (base_q + off) : '0;
  assign busy            = (state_q != S_IDLE);
  assign done            = done_q;

  // Next-state: accept start, advance issue counters.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    row_d    = row_q;
    bcol_d   = bcol_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          base_d   = base_addr;
          row_d    = '0;
          bcol_d   = '0;
          issued_d = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (issue) begin
          issued_d = issued_q + 1'b1;
          if (row_end) begin
            bcol_d = '0;
            row_d  = row_q + 1'b1;
          end else begin
            bcol_d = bcol_q + 1'b1;
          end
          if (mat_end) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && w_last) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the read tag pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      row_q      <= '0;
      bcol_q     <= '0;
      issued_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      row_q      <= row_d;
      bcol_q     <= bcol_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (issue) begin
        tag_q <= {row_q, row_end, mat_end};
      end
    end
  end

  weight_skid_fifo #(
    .W (EW)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   ({mem_data, tag_q}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign w_valid = (count != 2'd0);
  assign {w_data, w_row, w_row_last, w_last} = head;

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Bench for weight_fetch_sequencer: 2x4 matrix,
// burst 1 and burst 2 instances, scoreboarded.
module tb_weight_fetch_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Instance A: READ_BURST=1
  logic        a_start = 1'b0;
  logic [9:0]  a_base = '0;
  logic        a_re;
  logic [9:0]  a_ptr;
  logic [15:0] a_md = '0;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready = 1'b1;
  logic [0:0]  a_row;
  logic        a_rl;
  logic        a_last;
  logic        a_busy;
  logic        a_done;

  // Instance B: READ_BURST=2
  logic        b_start = 1'b0;
  logic [9:0]  b_base = '0;
  logic        b_re;
  logic [9:0]  b_ptr;
  logic [31:0] b_md = '0;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready = 1'b1;
  logic [0:0]  b_row;
  logic        b_rl;
  logic        b_last;
  logic        b_busy;
  logic        b_done;

  weight_fetch_sequencer #(
    .DATA_WIDTH (16), .ADDR_WIDTH (10),
    .READ_BURST (1), .ROWS (2), .COLS (4)
  ) u_a (
    .clk (clk), .rst_n (rst_n),
    .start (a_start), .base_addr (a_base),
    .mem_read_enable (a_re), .mem_pointer (a_ptr),
    .mem_data (a_md), .w_data (a_data),
    .w_valid (a_valid), .w_ready (a_ready),
    .w_row (a_row), .w_row_last (a_rl),
    .w_last (a_last), .busy (a_busy), .done (a_done)
  );

  weight_fetch_sequencer #(
    .DATA_WIDTH (16), .ADDR_WIDTH (10),
    .READ_BURST (2), .ROWS (2), .COLS (4)
  ) u_b (
    .clk (clk), .rst_n (rst_n),
    .start (b_start), .base_addr (b_base),
    .mem_read_enable (b_re), .mem_pointer (b_ptr),
    .mem_data (b_md), .w_data (b_data),
    .w_valid (b_valid), .w_ready (b_ready),
    .w_row (b_row), .w_row_last (b_rl),
    .w_last (b_last), .busy (b_busy), .done (b_done)
  );

  // Registered memories, mem[a] = a.
  always @(posedge clk) if (a_re) a_md <= {6'd0, a_ptr};
  always @(posedge clk)
    if (b_re) b_md <= {6'd0, b_ptr, 6'd0, b_ptr + 10'd1};

  logic [9:0]  qpa[$];
  logic [18:0] qda[$];
  logic [9:0]  qpb[$];
  logic [34:0] qdb[$];
  int          hs_a = 0;
  int          hs_b = 0;
  int          outst_a = 0;
  bit          stall_a = 0;
  logic [18:0] held_a;

  // Scoreboard monitor for A.
  always @(negedge clk) begin
    logic [9:0]  ep;
    logic [18:0] ed;
    if (!rst_n) begin
      qpa.delete();
      qda.delete();
      outst_a = 0;
      stall_a = 0;
    end else begin
      if (a_re) begin
        vectors++;
        if (qpa.size() == 0) begin
          errors++;
          $display("FAIL a_ptr: read %h, none expected", a_ptr);
        end else begin
          ep = qpa.pop_front();
          if (a_ptr !== ep) begin
            errors++;
            $display("FAIL a_ptr: got %h want %h", a_ptr, ep);
          end
        end
        outst_a++;
      end
      if (stall_a) begin
        vectors++;
        if (!a_valid || {a_data, a_row, a_rl, a_last} !== held_a) begin
          errors++;
          $display("FAIL a_hold: got v=%b %h want %h", a_valid,
                   {a_data, a_row, a_rl, a_last}, held_a);
        end
      end
      stall_a = 0;
      if (a_valid && a_ready) begin
        vectors++;
        if (qda.size() == 0) begin
          errors++;
          $display("FAIL a_out: beat %h, none expected",
                   {a_data, a_row, a_rl, a_last});
        end else begin
          ed = qda.pop_front();
          if ({a_data, a_row, a_rl, a_last} !== ed) begin
            errors++;
            $display("FAIL a_out: got %h want %h",
                     {a_data, a_row, a_rl, a_last}, ed);
          end
        end
        hs_a++;
        outst_a--;
      end else if (a_valid) begin
        stall_a = 1;
        held_a = {a_data, a_row, a_rl, a_last};
      end
      if (outst_a > 2) begin
        vectors++;
        errors++;
        $display("FAIL a_outst: got %0d want <=2", outst_a);
      end
    end
  end

  // Scoreboard monitor for B.
  always @(negedge clk) begin
    logic [9:0]  ep;
    logic [34:0] ed;
    if (!rst_n) begin
      qpb.delete();
      qdb.delete();
    end else begin
      if (b_re) begin
        vectors++;
        if (qpb.size() == 0) begin
          errors++;
          $display("FAIL b_ptr: read %h, none expected", b_ptr);
        end else begin
          ep = qpb.pop_front();
          if (b_ptr !== ep) begin
            errors++;
            $display("FAIL b_ptr: got %h want %h", b_ptr, ep);
          end
        end
      end
      if (b_valid && b_ready) begin
        vectors++;
        if (qdb.size() == 0) begin
          errors++;
          $display("FAIL b_out: beat %h, none expected",
                   {b_data, b_row, b_rl, b_last});
        end else begin
          ed = qdb.pop_front();
          if ({b_data, b_row, b_rl, b_last} !== ed) begin
            errors++;
            $display("FAIL b_out: got %h want %h",
                     {b_data, b_row, b_rl, b_last}, ed);
          end
        end
        hs_b++;
      end
    end
  end

  // Pushes the expected pass for A, pulses start.
  task automatic kick_a(input logic [9:0] base);
    logic [9:0] p;
    for (int i = 0; i < 8; i++) begin
      p = base + 10'(i);
      qpa.push_back(p);
      qda.push_back({6'd0, p, 1'(i / 4),
                     (i % 4) == 3, i == 7});
    end
    a_base  = base;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    vectors++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("FAIL a_accept: busy=%b want 1", a_busy);
    end
  endtask

  task automatic kick_b(input logic [9:0] base);
    logic [9:0] p;
    logic [9:0] p1;
    for (int i = 0; i < 4; i++) begin
      p  = base + 10'(2 * i);
      p1 = p + 10'd1;
      qpb.push_back(p);
      qdb.push_back({6'd0, p, 6'd0, p1, 1'(i / 2),
                     (i % 2) == 1, i == 3});
    end
    b_base  = base;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (a_done) return;
    end
    vectors++;
    errors++;
    $display("FAIL %s: done=0 want 1 (timeout)", tag);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({a_re, a_ptr, a_valid, a_data, a_row, a_rl,
         a_last, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL reset_a: got %h want 0",
               {a_re, a_ptr, a_valid, a_data, a_row,
                a_rl, a_last, a_busy, a_done});
    end
    vectors++;
    if ({b_re, b_ptr, b_valid, b_data, b_busy,
         b_done} !== '0) begin
      errors++;
      $display("FAIL reset_b: got %h want 0",
               {b_re, b_ptr, b_valid, b_data,
                b_busy, b_done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    int h0;
    a_ready = 1'b1;
    h0 = hs_a;
    kick_a(10'h000);
    vectors++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat0: valid=%b want 0", a_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (a_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1: valid=%b want 0", a_valid);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (a_valid !== 1'b1 || a_data !== 16'(k)) begin
        errors++;
        $display("FAIL stream%0d: v=%b d=%h want 1 %h",
                 k, a_valid, a_data, 16'(k));
      end
      @(posedge clk); #1;
    end
    vectors++;
    if ({a_done, a_busy, a_valid} !== 3'b100) begin
      errors++;
      $display("FAIL done_pulse: got %b want 100",
               {a_done, a_busy, a_valid});
    end
    @(posedge clk); #1;
    vectors++;
    if (a_done !== 1'b0 || hs_a - h0 != 8) begin
      errors++;
      $display("FAIL done_end: done=%b hs=%0d want 0 8",
               a_done, hs_a - h0);
    end
  endtask

  task automatic test_wrap;
    int h0;
    h0 = hs_a;
    kick_a(10'h3FC);
    wait_done_a("wrap_done");
    @(posedge clk); #1;
    vectors++;
    if (hs_a - h0 != 8 || qda.size() != 0
        || qpa.size() != 0) begin
      errors++;
      $display("FAIL wrap_cnt: hs=%0d left=%0d want 8 0",
               hs_a - h0, qda.size() + qpa.size());
    end
  endtask

  task automatic test_burst2;
    int h0;
    h0 = hs_b;
    kick_b(10'h000);
    for (int i = 0; i < 100 && !b_done; i++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (b_done !== 1'b1) begin
      errors++;
      $display("FAIL b_done: got %b want 1", b_done);
    end
    @(posedge clk); #1;
    vectors++;
    if (hs_b - h0 != 4 || qdb.size() != 0
        || qpb.size() != 0) begin
      errors++;
      $display("FAIL b_cnt: hs=%0d left=%0d want 4 0",
               hs_b - h0, qdb.size() + qpb.size());
    end
  endtask

  task automatic test_backpressure;
    int  h0;
    bit  seen;
    h0 = hs_a;
    seen = 0;
    a_ready = 1'b0;
    kick_a(10'h000);
    for (int i = 0; i < 400; i++) begin
      a_ready = (i < 4) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (a_done) begin
        seen = 1;
        break;
      end
    end
    a_ready = 1'b1;
    vectors++;
    if (!seen || hs_a - h0 != 8) begin
      errors++;
      $display("FAIL bp: done=%b hs=%0d want 1 8",
               seen, hs_a - h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int h0;
    a_ready = 1'b1;
    h0 = hs_a;
    kick_a(10'h000);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (hs_a - h0 >= 3) break;
    end
    vectors++;
    if (hs_a - h0 != 3) begin
      errors++;
      $display("FAIL mid_hs: got %0d want 3", hs_a - h0);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({a_re, a_ptr, a_valid, a_data, a_row, a_rl,
         a_last, a_busy, a_done} !== '0) begin
      errors++;
      $display("FAIL mid_rst: got %h want 0",
               {a_re, a_ptr, a_valid, a_data, a_row,
                a_rl, a_last, a_busy, a_done});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (a_valid !== 1'b0 || a_re !== 1'b0) begin
        errors++;
        $display("FAIL mid_idle: v=%b re=%b want 0 0",
                 a_valid, a_re);
      end
    end
    h0 = hs_a;
    kick_a(10'h000);
    wait_done_a("replay_done");
    @(posedge clk); #1;
    vectors++;
    if (hs_a - h0 != 8 || qda.size() != 0) begin
      errors++;
      $display("FAIL replay: hs=%0d want 8", hs_a - h0);
    end
  endtask

  task automatic test_start_ignored;
    int h0;
    a_ready = 1'b1;
    h0 = hs_a;
    kick_a(10'h000);
    repeat (3) @(posedge clk);
    #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_done_a("ign_done");
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    vectors++;
    if (a_busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_done_start: busy=%b want 0", a_busy);
    end
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (hs_a - h0 != 8 || a_busy !== 1'b0
        || qpa.size() != 0) begin
      errors++;
      $display("FAIL ign_cnt: hs=%0d busy=%b want 8 0",
               hs_a - h0, a_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t want finish", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_burst2();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
